// File: rtl/mem_rd_mux_n.sv
// N-source read-port arbiter sharing one in-order memory read channel.
// A tag FIFO records which source issued each read so responses are steered back.
module mem_rd_mux_n #(
    parameter int NUM_SRC         = 4,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 64,
    parameter int MAX_OUTSTANDING = 4,
    parameter int RR_EN           = 1,
    localparam int SRC_W          = (NUM_SRC > 2) ? $clog2(NUM_SRC) : 1,
    localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_SRC-1:0]          src_rd_req_val,
    input  logic [NUM_SRC*ADDR_W-1:0]   src_rd_req_addr,
    output logic [NUM_SRC-1:0]          src_rd_req_rdy,
    output logic [NUM_SRC-1:0]          src_rd_resp_val,
    output logic [DATA_W-1:0]           src_rd_resp_data,
    input  logic [NUM_SRC-1:0]          src_rd_resp_rdy,
    output logic                        dst_rd_req_val,
    output logic [ADDR_W-1:0]           dst_rd_req_addr,
    input  logic                        dst_rd_req_rdy,
    input  logic                        dst_rd_resp_val,
    input  logic [DATA_W-1:0]           dst_rd_resp_data,
    output logic                        dst_rd_resp_rdy,
    output logic [CNT_W-1:0]            outstanding_cnt
);

    // A depth-1 FIFO still gets a 1-bit pointer; occupancy never exceeds 1.
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int DEPTH = 1 << PTR_W;

    logic [SRC_W-1:0] last_grant;
    logic [SRC_W-1:0] grant;
    logic [SRC_W-1:0] head;
    logic [SRC_W-1:0] tag_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             any_req;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    assign any_req = |src_rd_req_val;
    assign full    = (cnt == CNT_W'(MAX_OUTSTANDING));
    assign empty   = (cnt == '0);
    assign head    = tag_mem[rd_ptr];

    // Grant depends only on request valids and last_grant, never on dst ready.
    always_comb begin
        logic             found;
        logic [SRC_W-1:0] idx;
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (RR_EN != 0) begin
                idx = SRC_W'((int'(last_grant) + 1 + k) % NUM_SRC);
            end else begin
                idx = SRC_W'(k);
            end
            if (!found && src_rd_req_val[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        dst_rd_req_addr = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant == SRC_W'(i)) begin
                dst_rd_req_addr = src_rd_req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    assign dst_rd_req_val = ~rst & any_req & ~full;

    always_comb begin
        src_rd_req_rdy = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant == SRC_W'(i)) begin
                src_rd_req_rdy[i] = ~rst & any_req & dst_rd_req_rdy & ~full;
            end
        end
    end

    // Response steering: only the head tag's source sees valid or drives ready.
    always_comb begin
        src_rd_resp_val = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (head == SRC_W'(i)) begin
                src_rd_resp_val[i] = ~rst & dst_rd_resp_val & ~empty;
            end
        end
    end

    assign dst_rd_resp_rdy  = ~rst & ~empty & src_rd_resp_rdy[head];
    assign src_rd_resp_data = dst_rd_resp_data;
    assign outstanding_cnt  = cnt;

    assign push = dst_rd_req_val & dst_rd_req_rdy;
    assign pop  = dst_rd_resp_val & dst_rd_resp_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt        <= '0;
            last_grant <= SRC_W'(NUM_SRC - 1);
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
            if ((RR_EN != 0) && push) begin
                last_grant <= grant;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr] <= grant;
        end
    end

    a_no_pop_empty: assert property (@(posedge clk) disable iff (rst)
        !(dst_rd_resp_val && dst_rd_resp_rdy && empty));
    a_no_push_full: assert property (@(posedge clk) disable iff (rst)
        !(push && full));
    a_rdy_onehot: assert property (@(posedge clk) $onehot0(src_rd_req_rdy));

endmodule

// File: tb/tb_mem_rd_mux_n.sv
// Directed scoreboard bench for mem_rd_mux_n: round-robin instance plus a fixed-priority instance.
module tb_mem_rd_mux_n;

    localparam int NS = 4;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int MO = 4;
    localparam int CW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Round-robin instance
    logic [NS-1:0]    src_val;
    logic [NS*AW-1:0] src_addr;
    logic [NS-1:0]    src_rdy_o;
    logic [NS-1:0]    src_resp_val_o;
    logic [DW-1:0]    src_resp_data_o;
    logic [NS-1:0]    src_resp_rdy;
    logic             dst_req_val_o;
    logic [AW-1:0]    dst_req_addr_o;
    logic             dst_req_rdy;
    logic             dst_resp_val;
    logic [DW-1:0]    dst_resp_data;
    logic             dst_resp_rdy_o;
    logic [CW-1:0]    cnt_o;

    logic             mem_auto;
    logic             auto_val;
    logic [DW-1:0]    auto_data;
    logic             man_val;
    logic [DW-1:0]    man_data;

    assign dst_resp_val  = mem_auto ? auto_val  : man_val;
    assign dst_resp_data = mem_auto ? auto_data : man_data;

    mem_rd_mux_n #(.NUM_SRC(NS), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MO), .RR_EN(1)) dut_rr (
        .clk(clk), .rst(rst),
        .src_rd_req_val(src_val), .src_rd_req_addr(src_addr), .src_rd_req_rdy(src_rdy_o),
        .src_rd_resp_val(src_resp_val_o), .src_rd_resp_data(src_resp_data_o), .src_rd_resp_rdy(src_resp_rdy),
        .dst_rd_req_val(dst_req_val_o), .dst_rd_req_addr(dst_req_addr_o), .dst_rd_req_rdy(dst_req_rdy),
        .dst_rd_resp_val(dst_resp_val), .dst_rd_resp_data(dst_resp_data), .dst_rd_resp_rdy(dst_resp_rdy_o),
        .outstanding_cnt(cnt_o)
    );

    // Fixed-priority instance with an always-ready memory that answers immediately
    logic [NS-1:0]    fp_val;
    logic [NS*AW-1:0] fp_addr;
    logic [NS-1:0]    fp_rdy_o;
    logic [NS-1:0]    fp_resp_val_o;
    logic [DW-1:0]    fp_resp_data_o;
    logic [NS-1:0]    fp_resp_rdy;
    logic             fp_req_val_o;
    logic [AW-1:0]    fp_req_addr_o;
    logic             fp_req_rdy;
    logic             fp_dresp_val;
    logic [DW-1:0]    fp_dresp_data;
    logic             fp_dresp_rdy_o;
    logic [CW-1:0]    fp_cnt_o;

    mem_rd_mux_n #(.NUM_SRC(NS), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MO), .RR_EN(0)) dut_fp (
        .clk(clk), .rst(rst),
        .src_rd_req_val(fp_val), .src_rd_req_addr(fp_addr), .src_rd_req_rdy(fp_rdy_o),
        .src_rd_resp_val(fp_resp_val_o), .src_rd_resp_data(fp_resp_data_o), .src_rd_resp_rdy(fp_resp_rdy),
        .dst_rd_req_val(fp_req_val_o), .dst_rd_req_addr(fp_req_addr_o), .dst_rd_req_rdy(fp_req_rdy),
        .dst_rd_resp_val(fp_dresp_val), .dst_rd_resp_data(fp_dresp_data), .dst_rd_resp_rdy(fp_dresp_rdy_o),
        .outstanding_cnt(fp_cnt_o)
    );

    typedef struct { int src; logic [AW-1:0] addr; } req_exp_t;
    typedef struct { int src; logic [DW-1:0] data; } resp_exp_t;
    typedef struct { logic [AW-1:0] addr; int t; } mreq_t;

    req_exp_t  req_q[$];
    resp_exp_t resp_q[$];
    req_exp_t  fp_q[$];
    mreq_t     mem_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (cnt_o != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(cnt_o), 64'd0);
    endtask

    // Memory model: in-order, answers two cycles after issue with data = addr + 1
    always @(posedge clk) begin
        if (rst) begin
            mem_q.delete();
        end else begin
            if (dst_resp_val && dst_resp_rdy_o && mem_q.size() > 0) mem_q.delete(0);
            if (dst_req_val_o && dst_req_rdy) mem_q.push_back('{dst_req_addr_o, cyc});
        end
    end

    always @(posedge clk) begin
        #1;
        if (mem_auto && mem_q.size() > 0 && cyc >= mem_q[0].t + 2) begin
            auto_val  = 1'b1;
            auto_data = DW'(mem_q[0].addr) + 64'd1;
        end else begin
            auto_val  = 1'b0;
            auto_data = '0;
        end
    end

    // Monitors: pop expected transaction whenever a handshake is presented
    always @(negedge clk) begin
        if (!rst && dst_req_val_o && dst_req_rdy) begin
            if (req_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL req_unexpected: addr 0x%0h issued, no request expected", dst_req_addr_o);
            end else begin
                req_exp_t e;
                e = req_q.pop_front();
                chk("req_addr", 64'(dst_req_addr_o), 64'(e.addr));
                chk("req_grant", 64'(src_rdy_o), 64'd1 << e.src);
            end
        end
        if (!rst && dst_resp_val && dst_resp_rdy_o) begin
            if (resp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL resp_unexpected: data 0x%0h accepted, no response expected", dst_resp_data);
            end else begin
                resp_exp_t r;
                r = resp_q.pop_front();
                chk("resp_route", 64'(src_resp_val_o), 64'd1 << r.src);
                chk("resp_data", src_resp_data_o, r.data);
            end
        end
        if (!rst && fp_req_val_o && fp_req_rdy) begin
            if (fp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL fp_req_unexpected: addr 0x%0h issued, no request expected", fp_req_addr_o);
            end else begin
                req_exp_t f;
                f = fp_q.pop_front();
                chk("fp_req_addr", 64'(fp_req_addr_o), 64'(f.addr));
                chk("fp_req_grant", 64'(fp_rdy_o), 64'd1 << f.src);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        src_addr     = {32'h30, 32'h20, 32'h10, 32'h100};
        src_resp_rdy = '1;
        mem_auto     = 1'b0;
        man_data     = '0;
        fp_addr      = {32'h30, 32'h20, 32'h10, 32'h0};
        fp_resp_rdy  = '1;
        fp_req_rdy   = 1'b1;
        fp_dresp_val = 1'b1;
        fp_dresp_data = '0;
        fp_val       = '0;
        // Everything active while in reset: outputs must stay forced low
        src_val      = 4'hF;
        dst_req_rdy  = 1'b1;
        man_val      = 1'b1;
        rst          = 1'b1;
        smp();
        chk("rst_req_val", 64'(dst_req_val_o), 64'd0);
        chk("rst_src_rdy", 64'(src_rdy_o), 64'd0);
        chk("rst_resp_val", 64'(src_resp_val_o), 64'd0);
        chk("rst_resp_rdy", 64'(dst_resp_rdy_o), 64'd0);
        step();
        rst = 1'b0; src_val = '0; dst_req_rdy = 1'b0; man_val = 1'b0;
        smp();
        chk("idle_cnt", 64'(cnt_o), 64'd0);
        chk("idle_req_val", 64'(dst_req_val_o), 64'd0);
        chk("idle_src_rdy", 64'(src_rdy_o), 64'd0);
        chk("idle_resp_rdy", 64'(dst_resp_rdy_o), 64'd0);

        // Single read from source 0
        step();
        src_val = 4'b0001; dst_req_rdy = 1'b1;
        req_q.push_back('{0, 32'h100});
        smp();
        chk("first_addr", 64'(dst_req_addr_o), 64'h100);
        step();
        src_val = '0;
        smp();
        chk("first_cnt", 64'(cnt_o), 64'd1);
        step();
        man_val = 1'b1; man_data = 64'hAA;
        resp_q.push_back('{0, 64'hAA});
        smp();
        chk("first_resp_val", 64'(src_resp_val_o), 64'b0001);
        chk("first_resp_data", src_resp_data_o, 64'hAA);
        step();
        man_val = 1'b0;
        src_addr[31:0] = 32'h0;
        smp();
        chk("first_cnt_after", 64'(cnt_o), 64'd0);

        // Fixed priority: source 0 starves others until it drops
        step();
        fp_val = 4'hF;
        repeat (3) fp_q.push_back('{0, 32'h0});
        fp_q.push_back('{1, 32'h10});
        repeat (3) step();
        fp_val = 4'b1110;
        smp();
        chk("fp_grant_src1", 64'(fp_rdy_o), 64'b0010);
        step();
        fp_val = '0;
        repeat (3) step();
        smp();
        chk("fp_cnt_drained", 64'(fp_cnt_o), 64'd0);

        // Round robin from reset: 0,1,2,3,0 with responses after two cycles
        step(); rst = 1'b1;
        step(); rst = 1'b0;
        mem_auto = 1'b1;
        foreach (req_q[i]) ;
        req_q.push_back('{0, 32'h00}); req_q.push_back('{1, 32'h10});
        req_q.push_back('{2, 32'h20}); req_q.push_back('{3, 32'h30});
        req_q.push_back('{0, 32'h00});
        resp_q.push_back('{0, 64'h01}); resp_q.push_back('{1, 64'h11});
        resp_q.push_back('{2, 64'h21}); resp_q.push_back('{3, 64'h31});
        resp_q.push_back('{0, 64'h01});
        step();
        src_val = 4'hF;
        repeat (5) step();
        src_val = '0;
        wait_drain("rr_drain", 30);
        chk("rr_req_all_issued", 64'(req_q.size()), 64'd0);
        chk("rr_resp_all_seen", 64'(resp_q.size()), 64'd0);

        // Full back-pressure with responses withheld
        step();
        mem_auto = 1'b0;
        src_val = 4'hF;
        req_q.push_back('{1, 32'h10}); req_q.push_back('{2, 32'h20});
        req_q.push_back('{3, 32'h30}); req_q.push_back('{0, 32'h00});
        repeat (4) step();
        smp();
        chk("full_cnt", 64'(cnt_o), 64'd4);
        chk("full_req_val", 64'(dst_req_val_o), 64'd0);
        chk("full_src_rdy", 64'(src_rdy_o), 64'd0);
        step();
        man_val = 1'b1; man_data = 64'h11;
        resp_q.push_back('{1, 64'h11});
        smp();
        chk("full_no_same_cycle_issue", 64'(dst_req_val_o), 64'd0);
        chk("full_pop_rdy", 64'(dst_resp_rdy_o), 64'd1);
        step();
        man_val = 1'b0;
        req_q.push_back('{1, 32'h10});
        smp();
        chk("refill_req_val", 64'(dst_req_val_o), 64'd1);
        chk("refill_cnt_before", 64'(cnt_o), 64'd3);
        step();
        src_val = '0;
        smp();
        chk("refill_cnt_after", 64'(cnt_o), 64'd4);
        resp_q.push_back('{2, 64'h21}); resp_q.push_back('{3, 64'h31});
        resp_q.push_back('{0, 64'h01}); resp_q.push_back('{1, 64'h11});
        step();
        mem_auto = 1'b1;
        wait_drain("full_drain", 30);

        // Head-of-line blocking, then simultaneous push and pop
        step();
        mem_auto = 1'b0;
        src_val = 4'b0010;
        req_q.push_back('{1, 32'h10});
        step();
        src_val = 4'b0100;
        req_q.push_back('{2, 32'h20});
        step();
        src_val = '0;
        smp();
        chk("hol_cnt_setup", 64'(cnt_o), 64'd2);
        step();
        src_resp_rdy = 4'b1101; man_val = 1'b1; man_data = 64'h55;
        smp();
        chk("hol_dst_rdy", 64'(dst_resp_rdy_o), 64'd0);
        chk("hol_resp_val", 64'(src_resp_val_o), 64'b0010);
        step();
        smp();
        chk("hol_cnt_stalled", 64'(cnt_o), 64'd2);
        step();
        src_resp_rdy = 4'hF; src_val = 4'b1000;
        req_q.push_back('{3, 32'h30});
        resp_q.push_back('{1, 64'h55});
        smp();
        chk("pushpop_req_val", 64'(dst_req_val_o), 64'd1);
        chk("pushpop_resp_rdy", 64'(dst_resp_rdy_o), 64'd1);
        step();
        src_val = '0; man_val = 1'b0;
        smp();
        chk("pushpop_cnt", 64'(cnt_o), 64'd2);
        resp_q.push_back('{2, 64'h21}); resp_q.push_back('{3, 64'h31});
        step();
        mem_auto = 1'b1;
        wait_drain("hol_drain", 30);

        // Reset with three reads in flight
        step();
        mem_auto = 1'b0;
        src_val = 4'hF;
        req_q.push_back('{0, 32'h00}); req_q.push_back('{1, 32'h10});
        req_q.push_back('{2, 32'h20});
        repeat (3) step();
        src_val = '0;
        smp();
        chk("midrst_cnt_before", 64'(cnt_o), 64'd3);
        step(); rst = 1'b1;
        step(); rst = 1'b0;
        smp();
        chk("midrst_cnt_after", 64'(cnt_o), 64'd0);
        step();
        man_val = 1'b1; man_data = 64'hDEAD;
        smp();
        chk("stray_resp_rdy", 64'(dst_resp_rdy_o), 64'd0);
        chk("stray_resp_val", 64'(src_resp_val_o), 64'd0);
        step();
        man_val = 1'b0; src_val = 4'hF;
        req_q.push_back('{0, 32'h00});
        smp();
        chk("post_rst_grant", 64'(src_rdy_o), 64'b0001);
        step();
        src_val = '0;
        smp();
        chk("post_rst_cnt", 64'(cnt_o), 64'd1);
        resp_q.push_back('{0, 64'h01});
        step();
        mem_auto = 1'b1;
        wait_drain("post_rst_drain", 30);

        chk("req_q_empty", 64'(req_q.size()), 64'd0);
        chk("resp_q_empty", 64'(resp_q.size()), 64'd0);
        chk("fp_q_empty", 64'(fp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_rd_mux_n.md
Name: mem_rd_mux_n

Overview:
N-source read-port arbiter that shares one memory read channel (request + response) among NUM_SRC clients.
Supports up to MAX_OUTSTANDING in-flight reads, so back-to-back issue is possible without waiting for each response.
Arbitration is fixed-priority (lowest index wins) or round-robin, selected by parameter.
The downstream memory returns responses in request order; the block steers each response to its issuing source via an internal tag FIFO.

Parameters:
NUM_SRC, 4, number of requesting sources (>=2)
ADDR_W, 32, read address width
DATA_W, 64, read data width
MAX_OUTSTANDING, 4, tag FIFO depth = max reads issued but not yet responded (>=1, power of 2)
RR_EN, 1, 1 = round-robin arbitration, 0 = fixed priority (source 0 highest)
(local) SRC_W = max(1, $clog2(NUM_SRC)); CNT_W = $clog2(MAX_OUTSTANDING+1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
src_rd_req_val  in  NUM_SRC  per-source request valid
src_rd_req_addr  in  NUM_SRC*ADDR_W  per-source address; source i occupies bits [i*ADDR_W +: ADDR_W]
src_rd_req_rdy  out  NUM_SRC  per-source request accept
src_rd_resp_val  out  NUM_SRC  per-source response valid
src_rd_resp_data  out  DATA_W  response data, broadcast to all sources
src_rd_resp_rdy  in  NUM_SRC  per-source response ready
dst_rd_req_val  out  1  request to memory
dst_rd_req_addr  out  ADDR_W  address of the granted source
dst_rd_req_rdy  in  1  memory accepts request
dst_rd_resp_val  in  1  memory response valid
dst_rd_resp_data  in  DATA_W  memory response data
dst_rd_resp_rdy  out  1  mux accepts response
outstanding_cnt  out  CNT_W  current tag FIFO occupancy

Behaviour:
- Reset: clk rising edge with rst=1 clears the tag FIFO (empty, outstanding_cnt=0) and sets the RR pointer last_grant = NUM_SRC-1, so source 0 is first in RR order. While rst=1, all val/rdy outputs are forced to 0. A reset asserted mid-transaction discards all in-flight tags; any memory responses arriving afterward are not accepted (dst_rd_resp_rdy=0 while empty).
- Grant selection is combinational, computed from src_rd_req_val and last_grant only; it never depends on dst_rd_req_rdy.
  - RR_EN=0: lowest index with val=1.
  - RR_EN=1: first index with val=1 searching last_grant+1, last_grant+2, ... with wrap mod NUM_SRC.
- dst_rd_req_val = (|src_rd_req_val) & ~full.
- dst_rd_req_addr = address of the granted source. It is don't-care when dst_rd_req_val=0.
- src_rd_req_rdy[g] = dst_rd_req_rdy & ~full for the granted g only; all other bits are 0.
- Request handshake (dst_rd_req_val & dst_rd_req_rdy), on that clock edge:
  - push g into the tag FIFO;
  - last_grant <= g, RR mode only. last_grant does not move without a handshake.
- Sources obey valid/ready: once val is raised, val and addr are held until accepted. The grant may change while val is held only if a higher-priority source raises val (fixed priority); this is legal.
- full = (outstanding_cnt == MAX_OUTSTANDING). When full, no request is issued, even if a response pops in the same cycle; this keeps the rdy path free of response-side logic.
- Response path, with h = FIFO head tag:
  - src_rd_resp_val[h] = dst_rd_resp_val & ~empty; all other bits are 0.
  - dst_rd_resp_rdy = ~empty & src_rd_resp_rdy[h].
  - src_rd_resp_data = dst_rd_resp_data, combinational.
  - Handshake (dst_rd_resp_val & dst_rd_resp_rdy) pops the head.
- Latency: zero added cycles on both the request path and the response path (pure combinational steering). Sustains 1 request/cycle and 1 response/cycle.
- Simultaneous push and pop (not full): occupancy is unchanged and both pointers advance.
- Pointers are $clog2(MAX_OUTSTANDING) bits and wrap naturally. full/empty come from outstanding_cnt.
- A response whose head source holds rdy=0 stalls all later responses (in-order). This is intended head-of-line behaviour.
- Assertions in sim: no dst response accepted while empty; no push while full; src_rd_req_rdy is one-hot or zero.

Test Plan:
- Reset then idle: after rst, all rdy/val are 0 and outstanding_cnt=0. Raise src0 val with addr=0x100 and dst_rd_req_rdy=1 -> dst_rd_req_addr=0x100, handshake in cycle 0, outstanding_cnt=1. A memory response with data=0xAA reaches src0 the same cycle it is presented.
- Fixed priority (RR_EN=0): all 4 sources hold val with addrs 0x0/0x10/0x20/0x30 and memory is always ready -> issue order 0,0,0... (src0 starves the others). Drop src0 val -> src1 is granted next cycle.
- Round robin (RR_EN=1): same stimulus, with memory responding after 2 cycles -> issue order 0,1,2,3,0. Each response is delivered to the matching source in the same order, with data = addr+1.
- Full back-pressure: MAX_OUTSTANDING=4, responses withheld -> 4 issues, then dst_rd_req_val=0 and src rdy=0 while outstanding_cnt=4. Release one response -> the next request issues the following cycle, not the same cycle.
- Head-of-line and simultaneous push/pop: tags [1,2] outstanding and src1 resp_rdy=0 -> dst_rd_resp_rdy=0 and src2 gets no val. Raise src1 rdy in the same cycle as a new src3 request issues -> pop and push together, and outstanding_cnt stays 2.
- Reset mid-flight: with 3 outstanding, pulse rst -> outstanding_cnt=0. A stray dst_rd_resp_val=1 afterward is not accepted (dst_rd_resp_rdy=0), and the next request goes to source 0 in RR mode.
